// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage pipeline register with a valid/ready
// handshake and a 2-entry skid buffer (main + skid). in_ready is registered so
// no combinational ready path crosses the stage. Flush kills held and incoming
// entries and forces the control field to the CTRL_BUBBLE (NOP) value.
// Optional feature macro: PIPE_STAGE_STATS_EN adds saturating stall/bubble
// performance counters (stall_cnt, bubble_cnt).
module pipe_stage_skid #(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_ready_q;
  logic                accept;
  logic                deliver;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  // Mask the head entry so downstream sees a clean NOP whenever nothing is live.
  assign out_data  = out_valid ? main_data_q : '0;
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  // Next-state and storage steering for the EMPTY/ONE/FULL occupancy machine.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d     = S_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      S_ONE: begin
        if (accept && deliver) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (accept) begin
          state_d     = S_FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (deliver) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only a delivery can change anything.
        if (deliver) begin
          state_d     = S_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush overrides the handshake: held entries and the incoming one are dropped.
    if (flush) begin
      state_d     = S_EMPTY;
      main_data_d = '0;
      main_ctrl_d = CTRL_BUBBLE;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_BUBBLE;
    end
  end

  // State, payload storage and registered in_ready.
  // NOTE: sequential state uses non-blocking assignments only; the skid entry is
  // reset too because a flush/reset must leave no stale payload behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= (state_d != S_FULL);
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating perf counters; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
